// File: rtl/vga_timing_gen_if.sv
// VGA raster timing bundle: coordinates, syncs, blank and frame pulses.
// frame_count exists only when VGA_FRAME_COUNT_EN is defined.
interface vga_timing_gen_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       hs;
  logic       vs;
  logic       blank;
  logic       frame_start;
  logic       vblank_start;
`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] frame_count;

  modport master (
    output DrawX, DrawY, hs, vs, blank,
    output frame_start, vblank_start, frame_count
  );
  modport slave (
    input DrawX, DrawY, hs, vs, blank,
    input frame_start, vblank_start, frame_count
  );
`else
  modport master (
    output DrawX, DrawY, hs, vs, blank,
    output frame_start, vblank_start
  );
  modport slave (
    input DrawX, DrawY, hs, vs, blank,
    input frame_start, vblank_start
  );
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// VGA 640x480@60 raster timing generator, fully registered outputs.
// Optional VGA_FRAME_COUNT_EN adds an 8-bit frame counter.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  vga_timing_gen_if.master vga
);

  localparam int unsigned H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0]  H_MAX = 10'(H_TOT - 1);
  localparam logic [9:0]  V_MAX = 10'(V_TOT - 1);
  localparam logic [9:0]  V_VIS = 10'(V_VISIBLE);
  localparam logic [10:0] H_VIS = 11'(H_VISIBLE);
  localparam logic [10:0] V_VISW = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       blank_q, blank_d;
  logic       fs_q, fs_d;
  logic       vb_q, vb_d;
  logic [10:0] xw, yw;

  always_comb begin
    x_d = x_q + 10'd1;
    y_d = y_q;
    if (x_q == H_MAX) begin
      x_d = '0;
      y_d = (y_q == V_MAX) ? '0 : y_q + 10'd1;
    end
    xw = {1'b0, x_d};
    yw = {1'b0, y_d};
    // Flags come from the next coordinates so they line up with them.
    hs_d    = !(xw >= HS_START && xw < HS_END);
    vs_d    = !(yw >= VS_START && yw < VS_END);
    blank_d = (xw < H_VIS) && (yw < V_VISW);
    fs_d    = (x_d == '0) && (y_d == '0);
    vb_d    = (x_d == '0) && (y_d == V_VIS);
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      x_q     <= '0;
      y_q     <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b1;
      fs_q    <= 1'b0;
      vb_q    <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      fs_q    <= fs_d;
      vb_q    <= vb_d;
    end
  end

  assign vga.DrawX        = x_q;
  assign vga.DrawY        = y_q;
  assign vga.hs           = hs_q;
  assign vga.vs           = vs_q;
  assign vga.blank        = blank_q;
  assign vga.frame_start  = fs_q;
  assign vga.vblank_start = vb_q;

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] fc_q, fc_d;

  always_comb begin
    fc_d = fc_q + {7'd0, vb_d};
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) fc_q <= '0;
    else          fc_q <= fc_d;
  end

  assign vga.frame_count = fc_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a small-raster instance and a
// default 640x480 instance checked against an arithmetic raster model.
module tb_vga_timing_gen;

  localparam int SHV = 8, SHF = 2, SHS = 3, SHB = 3;
  localparam int SVV = 6, SVF = 1, SVS = 2, SVB = 2;
  localparam int SFR = (SHV + SHF + SHS + SHB) * (SVV + SVF + SVS + SVB);

  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;

  vga_timing_gen_if s_if ();
  vga_timing_gen_if d_if ();

  vga_timing_gen #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
  ) u_small (
    .vga_clk(vga_clk),
    .reset_n(reset_n),
    .vga(s_if)
  );

  vga_timing_gen u_def (
    .vga_clk(vga_clk),
    .reset_n(reset_n),
    .vga(d_if)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       fs;
    logic       vb;
    logic [7:0] fc;
  } exp_t;

  exp_t qs[$];
  exp_t qd[$];
  int   checks = 0;
  int   errors = 0;
  longint n = 0;

  // n = cycles since reset released; the raster is a pure function of n.
  function automatic exp_t model(longint c, int hv, int hf, int hsw,
                                 int hb, int vv, int vf, int vsw, int vb);
    exp_t   e;
    longint ht, vt, f, x, y, m;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    f  = ht * vt;
    x  = c % ht;
    y  = (c / ht) % vt;
    m  = c % f;
    e.x     = 10'(x);
    e.y     = 10'(y);
    e.hs    = !(x >= hv + hf && x < hv + hf + hsw);
    e.vs    = !(y >= vv + vf && y < vv + vf + vsw);
    e.blank = (x < hv) && (y < vv);
    e.fs    = (c > 0) && (m == 0);
    e.vb    = (m == vv * ht);
    e.fc    = (c >= vv * ht) ? 8'((((c - vv * ht) / f) + 1) % 256) : 8'd0;
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input exp_t a);
    chk({tag, ".DrawX"}, int'(a.x), int'(e.x));
    chk({tag, ".DrawY"}, int'(a.y), int'(e.y));
    chk({tag, ".hs"}, int'(a.hs), int'(e.hs));
    chk({tag, ".vs"}, int'(a.vs), int'(e.vs));
    chk({tag, ".blank"}, int'(a.blank), int'(e.blank));
    chk({tag, ".frame_start"}, int'(a.fs), int'(e.fs));
    chk({tag, ".vblank_start"}, int'(a.vb), int'(e.vb));
`ifdef VGA_FRAME_COUNT_EN
    chk({tag, ".frame_count"}, int'(a.fc), int'(e.fc));
`endif
  endtask

  // Drive reset_n for the next posedge and queue what that edge must give.
  task automatic step(input logic rst_n);
    @(negedge vga_clk);
    reset_n = rst_n;
    if (!rst_n) n = 0;
    else        n++;
    qs.push_back(model(n, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB));
    qd.push_back(model(n, 640, 16, 96, 48, 480, 10, 2, 33));
  endtask

  initial begin : monitor
    exp_t e, a;
    forever begin
      @(posedge vga_clk);
      #2;
      if (qs.size() > 0) begin
        e = qs.pop_front();
        a = '0;
        a.x = s_if.DrawX; a.y = s_if.DrawY;
        a.hs = s_if.hs; a.vs = s_if.vs; a.blank = s_if.blank;
        a.fs = s_if.frame_start; a.vb = s_if.vblank_start;
`ifdef VGA_FRAME_COUNT_EN
        a.fc = s_if.frame_count;
`endif
        cmp("small", e, a);
      end
      if (qd.size() > 0) begin
        e = qd.pop_front();
        a = '0;
        a.x = d_if.DrawX; a.y = d_if.DrawY;
        a.hs = d_if.hs; a.vs = d_if.vs; a.blank = d_if.blank;
        a.fs = d_if.frame_start; a.vb = d_if.vblank_start;
`ifdef VGA_FRAME_COUNT_EN
        a.fc = d_if.frame_count;
`endif
        cmp("default", e, a);
      end
    end
  end

  initial begin : driver
    int hold;
    for (int i = 0; i < 5; i++) step(1'b0);
    // Long clean run: 260 small frames wraps the 8-bit frame counter.
    for (int i = 0; i < 260 * SFR + 20; i++) step(1'b1);
    // Mid-frame reset at small-raster (5,3).
    while (n % SFR != 3 * 16 + 4) step(1'b1);
    step(1'b0);
    for (int i = 0; i < 2 * SFR; i++) step(1'b1);
    // Reset on the edge that would carry frame_start drops the pulse.
    while (n % SFR != SFR - 1) step(1'b1);
    step(1'b0);
    for (int i = 0; i < SFR + 10; i++) step(1'b1);
    // Reset on the edge that would carry vblank_start.
    while (n % SFR != SVV * 16 - 1) step(1'b1);
    step(1'b0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        hold = int'($urandom_range(1, 4));
        for (int k = 0; k < hold; k++) step(1'b0);
      end else begin
        step(1'b1);
      end
    end
    @(posedge vga_clk);
    #4;
    chk("scoreboard_small_drained", qs.size(), 0);
    chk("scoreboard_default_drained", qd.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
